// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable synchronized lock,
// then releases five downstream domain resets one after another and watches for loss of lock.
module pll_rst_seq #(
  parameter int PULSE_LEN  = 16,
  parameter int STABLE_LEN = 1024,
  parameter int TIMEOUT    = 65536,
  parameter int REL_GAP    = 8,
  parameter int MAX_RETRY  = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic [4:0] dom_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [1:0] retry_cnt,
  output logic [7:0] lol_cnt
);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN,
    FAIL
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] cnt_reg, cnt_next;
  logic        pll_rst_reg, pll_rst_next;
  logic [4:0]  dom_reg, dom_next;
  logic        ready_reg, ready_next;
  logic        fail_reg, fail_next;
  logic [1:0]  retry_reg, retry_next;
  logic [7:0]  lol_reg, lol_next;
  logic [1:0]  retry_inc;
  logic        sync1_reg, lock_s;

  assign retry_inc = retry_reg + 2'd1;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    pll_rst_next = pll_rst_reg;
    dom_next     = dom_reg;
    ready_next   = ready_reg;
    fail_next    = fail_reg;
    retry_next   = retry_reg;
    lol_next     = lol_reg;

    // restart outranks every state transition, including a simultaneous loss of lock
    if (restart) begin
      state_next   = RESET_PLL;
      cnt_next     = '0;
      pll_rst_next = 1'b1;
      dom_next     = '0;
      ready_next   = 1'b0;
      if (state_reg == FAIL) begin
        fail_next  = 1'b0;
        retry_next = '0;
      end
    end else begin
      case (state_reg)
        RESET_PLL: begin
          if (cnt_reg == 32'(PULSE_LEN - 1)) begin
            state_next   = WAIT_LOCK;
            cnt_next     = '0;
            pll_rst_next = 1'b0;
          end else begin
            cnt_next = cnt_reg + 32'd1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_next = STABLE;
            cnt_next   = '0;
          end else if (cnt_reg == 32'(TIMEOUT - 1)) begin
            retry_next   = retry_inc;
            cnt_next     = '0;
            pll_rst_next = 1'b1;
            if ({30'd0, retry_inc} == 32'(MAX_RETRY)) begin
              state_next = FAIL;
              fail_next  = 1'b1;
            end else begin
              state_next = RESET_PLL;
            end
          end else begin
            cnt_next = cnt_reg + 32'd1;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end else if (cnt_reg == 32'(STABLE_LEN - 1)) begin
            state_next = RELEASE;
            cnt_next   = '0;
            dom_next   = 5'b00001;
          end else begin
            cnt_next = cnt_reg + 32'd1;
          end
        end
        RELEASE: begin
          // released bits form a thermometer code; the top bit marks the last release
          if (!lock_s) begin
            state_next   = RESET_PLL;
            cnt_next     = '0;
            pll_rst_next = 1'b1;
            dom_next     = '0;
          end else if (dom_reg[4]) begin
            state_next = RUN;
            cnt_next   = '0;
            ready_next = 1'b1;
            retry_next = '0;
          end else if (cnt_reg == 32'(REL_GAP - 1)) begin
            cnt_next = '0;
            dom_next = {dom_reg[3:0], 1'b1};
          end else begin
            cnt_next = cnt_reg + 32'd1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_next   = RESET_PLL;
            cnt_next     = '0;
            pll_rst_next = 1'b1;
            dom_next     = '0;
            ready_next   = 1'b0;
            if (lol_reg != 8'hFF) lol_next = lol_reg + 8'd1;
          end
        end
        FAIL: begin
          pll_rst_next = 1'b1;
          dom_next     = '0;
          ready_next   = 1'b0;
          fail_next    = 1'b1;
        end
        default: begin
          state_next   = RESET_PLL;
          cnt_next     = '0;
          pll_rst_next = 1'b1;
          dom_next     = '0;
          ready_next   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg   <= 1'b0;
      lock_s      <= 1'b0;
      state_reg   <= RESET_PLL;
      cnt_reg     <= '0;
      pll_rst_reg <= 1'b1;
      dom_reg     <= '0;
      ready_reg   <= 1'b0;
      fail_reg    <= 1'b0;
      retry_reg   <= '0;
      lol_reg     <= '0;
    end else begin
      sync1_reg   <= pll_locked;
      lock_s      <= sync1_reg;
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pll_rst_reg <= pll_rst_next;
      dom_reg     <= dom_next;
      ready_reg   <= ready_next;
      fail_reg    <= fail_next;
      retry_reg   <= retry_next;
      lol_reg     <= lol_next;
    end
  end

  assign pll_rst   = pll_rst_reg;
  assign dom_rst_n = dom_reg;
  assign ready     = ready_reg;
  assign fail      = fail_reg;
  assign retry_cnt = retry_reg;
  assign lol_cnt   = lol_reg;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq with short parameters; expected values are hand-derived
// edge counts relative to each phase's reference edge.
module tb_pll_rst_seq;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic [4:0] dom_rst_n;
  logic       ready;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [7:0] lol_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pll_rst_seq #(
    .PULSE_LEN (4),
    .STABLE_LEN(8),
    .TIMEOUT   (32),
    .REL_GAP   (2),
    .MAX_RETRY (2)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .restart   (restart),
    .pll_rst   (pll_rst),
    .dom_rst_n (dom_rst_n),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .lol_cnt   (lol_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pll_locked = 1'b0;
    restart = 1'b0;
    tick(3);
    check_val("rst_pll_rst",   32'(pll_rst),   32'h1);
    check_val("rst_dom",       32'(dom_rst_n), 32'h0);
    check_val("rst_ready",     32'(ready),     32'h0);
    check_val("rst_fail",      32'(fail),      32'h0);
    check_val("rst_retry",     32'(retry_cnt), 32'h0);
    check_val("rst_lol",       32'(lol_cnt),   32'h0);

    // nominal bring-up; edges numbered from the first edge after release
    rst_n = 1'b1;
    tick(3);  check_val("nom_pulse_e3",  32'(pll_rst), 32'h1);
    tick(1);  check_val("nom_pulse_e4",  32'(pll_rst), 32'h0);
    tick(6);  pll_locked = 1'b1;
    tick(10); check_val("nom_dom_e20",   32'(dom_rst_n), 32'h00);
    tick(1);  check_val("nom_dom_e21",   32'(dom_rst_n), 32'h01);
    tick(2);  check_val("nom_dom_e23",   32'(dom_rst_n), 32'h03);
    tick(5);  check_val("nom_dom_e28",   32'(dom_rst_n), 32'h0F);
    tick(1);  check_val("nom_dom_e29",   32'(dom_rst_n), 32'h1F);
              check_val("nom_ready_e29", 32'(ready),     32'h0);
    tick(1);  check_val("nom_ready_e30", 32'(ready),     32'h1);
              check_val("nom_retry",     32'(retry_cnt), 32'h0);

    // loss of lock in RUN, then relock
    tick(2);  pll_locked = 1'b0;
    tick(2);  check_val("lol_ready_e2",  32'(ready),     32'h1);
    tick(1);  check_val("lol_ready_e3",  32'(ready),     32'h0);
              check_val("lol_dom_e3",    32'(dom_rst_n), 32'h00);
              check_val("lol_pll_rst",   32'(pll_rst),   32'h1);
              check_val("lol_cnt_1",     32'(lol_cnt),   32'h1);
    pll_locked = 1'b1;
    tick(4);  check_val("lol_pulse_end", 32'(pll_rst),   32'h0);
    tick(17); check_val("lol_ready_e24", 32'(ready),     32'h0);
    tick(1);  check_val("lol_ready_e25", 32'(ready),     32'h1);
              check_val("lol_dom_e25",   32'(dom_rst_n), 32'h1F);

    // restart coinciding with loss of lock, then timeout into FAIL
    tick(2);  pll_locked = 1'b0;
    tick(2);  restart = 1'b1;
    tick(1);  restart = 1'b0;
              check_val("rlol_lol",      32'(lol_cnt),   32'h1);
              check_val("rlol_pll_rst",  32'(pll_rst),   32'h1);
              check_val("rlol_ready",    32'(ready),     32'h0);
    tick(4);  check_val("to_wait1",      32'(pll_rst),   32'h0);
    tick(31); check_val("to_pre1_rst",   32'(pll_rst),   32'h0);
              check_val("to_pre1_retry", 32'(retry_cnt), 32'h0);
    tick(1);  check_val("to_1_rst",      32'(pll_rst),   32'h1);
              check_val("to_1_retry",    32'(retry_cnt), 32'h1);
              check_val("to_1_fail",     32'(fail),      32'h0);
    tick(3);  check_val("to_pulse2_e3",  32'(pll_rst),   32'h1);
    tick(1);  check_val("to_pulse2_e4",  32'(pll_rst),   32'h0);
    tick(31); check_val("to_pre2_fail",  32'(fail),      32'h0);
    tick(1);  check_val("to_2_fail",     32'(fail),      32'h1);
              check_val("to_2_retry",    32'(retry_cnt), 32'h2);
              check_val("to_2_rst",      32'(pll_rst),   32'h1);
    tick(5);  check_val("fail_hold",     32'(fail),      32'h1);
              check_val("fail_pll_rst",  32'(pll_rst),   32'h1);
              check_val("fail_dom",      32'(dom_rst_n), 32'h00);

    // held restart out of FAIL, then a one-cycle lock glitch at STABLE count 5
    restart = 1'b1;
    tick(1);  check_val("rec_fail",      32'(fail),      32'h0);
              check_val("rec_retry",     32'(retry_cnt), 32'h0);
              check_val("rec_pll_rst",   32'(pll_rst),   32'h1);
    tick(2);  restart = 1'b0;
    tick(3);  check_val("rec_pulse_e6",  32'(pll_rst),   32'h1);
    tick(1);  check_val("rec_pulse_e7",  32'(pll_rst),   32'h0);
    pll_locked = 1'b1;
    tick(6);  pll_locked = 1'b0;
    tick(1);  pll_locked = 1'b1;
    tick(6);  check_val("gl_dom_e20",    32'(dom_rst_n), 32'h00);
    tick(4);  check_val("gl_dom_e24",    32'(dom_rst_n), 32'h00);
    tick(1);  check_val("gl_dom_e25",    32'(dom_rst_n), 32'h01);
    tick(9);  check_val("gl_ready",      32'(ready),     32'h1);
              check_val("gl_retry",      32'(retry_cnt), 32'h0);
              check_val("gl_dom_full",   32'(dom_rst_n), 32'h1F);

    // asynchronous reset in the middle of RELEASE
    restart = 1'b1;
    tick(1);  restart = 1'b0;
    tick(13); check_val("mr_dom_e14",    32'(dom_rst_n), 32'h01);
    tick(2);  check_val("mr_dom_e16",    32'(dom_rst_n), 32'h03);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mr_dom",     32'(dom_rst_n), 32'h00);
    check_val("mr_pll_rst", 32'(pll_rst),   32'h1);
    check_val("mr_ready",   32'(ready),     32'h0);
    check_val("mr_lol",     32'(lol_cnt),   32'h0);
    check_val("mr_retry",   32'(retry_cnt), 32'h0);
    check_val("mr_fail",    32'(fail),      32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
